sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Arbitrates the CPU core's two sram-like master ports, instruction fetch and data memory, onto one shared sram-like port toward the cache or bridge. It sits between `mips` and the memory-side adapter. It allows one outstanding transaction at a time. The winner's request fields are captured on grant, so the shared port stays stable even if a requester withdraws its request (e.g. on flush).

## Interface
Parameters:
- none (32-bit address/data and 2-bit size are fixed by the sram-like protocol)

Ports:
- `clk`  in  1  system clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `inst_req` / `inst_wr` / `inst_size` / `inst_addr` / `inst_wdata`  in  1/1/2/32/32  instruction requester request fields
- `inst_rdata`  out  32  read data to instruction requester
- `inst_addr_ok`  out  1  request accepted, to instruction requester
- `inst_data_ok`  out  1  transaction complete, to instruction requester
- `data_req` / `data_wr` / `data_size` / `data_addr` / `data_wdata`  in  1/1/2/32/32  data requester request fields
- `data_rdata`  out  32  read data to data requester
- `data_addr_ok`  out  1  request accepted, to data requester
- `data_data_ok`  out  1  transaction complete, to data requester
- `mem_req` / `mem_wr` / `mem_size` / `mem_addr` / `mem_wdata`  out  1/1/2/32/32  shared-port request fields
- `mem_rdata`  in  32  shared-port read data
- `mem_addr_ok`  in  1  shared-port request accepted
- `mem_data_ok`  in  1  shared-port transaction complete

## Operation
- **State machine:** five states, IDLE, I_ADDR, I_DATA, D_ADDR, D_DATA. There is also a one-bit `last_owner` (0 = inst, 1 = data).
- **Arbitration point.** The arbiter arbitrates in IDLE, and also in I_DATA/D_DATA on the cycle `mem_data_ok` = 1.
  - Only `data_req` = 1: grant data.
  - Only `inst_req` = 1: grant inst.
  - Both = 1: grant the port that is not `last_owner`.
  - Neither: go to or stay in IDLE.
- **Grant edge.**
  - Capture the winner's wr/size/addr/wdata into the `mem_*` field registers.
  - Set `last_owner` to the winner.
  - Next state is I_ADDR or D_ADDR.
- **x_ADDR states.**
  - `mem_req` = 1.
  - The owner's `addr_ok` equals `mem_addr_ok` (combinational). The other port's `addr_ok` = 0.
  - On `mem_addr_ok` = 1, go to x_DATA.
- **x_DATA states.**
  - `mem_req` = 0.
  - The owner's `data_ok` equals `mem_data_ok` (combinational).
  - On `mem_data_ok` = 1, re-arbitrate as above.
- **Read data.** `inst_rdata` = `data_rdata` = `mem_rdata` unconditionally. Only the `data_ok` strobes are qualified by ownership.
- **Spurious strobes.** `mem_addr_ok` outside x_ADDR and `mem_data_ok` outside x_DATA are ignored. They never reach either requester and never change state.
- **Withdrawn request.** A request withdrawn after grant still completes on the shared port. The owner still receives `addr_ok` and `data_ok` pulses, and the requester must tolerate them.
- **Same-cycle re-request.** A requester re-asserting `req` in the same cycle as its own `data_ok` is treated as a new request and is eligible for that cycle's arbitration.

## Timing
- **Reset values:**
  - State = IDLE, `last_owner` = 0.
  - `mem_req` = 0, `mem_wr` = 0, `mem_size` = 0, `mem_addr` = 0, `mem_wdata` = 0.
  - All `addr_ok` and `data_ok` outputs = 0.
- **Reset mid-transaction** discards the transaction with no `data_ok`. The downstream adapter shares `rst`, so it also drops the transaction.
- **Latency from request to shared port:**
  - A request sampled in IDLE at edge T gives `mem_req` = 1 in cycle T+1.
  - Fastest acceptance: `mem_addr_ok` in T+1 gives owner `addr_ok` in T+1.
  - `mem_data_ok` is earliest in T+2, giving owner `data_ok` in T+2.
- **Back-to-back:** a pending request gives the next `mem_req` in the cycle after `data_ok`, with no IDLE bubble.
- **Fields during ADDR:** `mem_wr`/`mem_size`/`mem_addr`/`mem_wdata` are held constant through the x_ADDR and x_DATA states of a transaction.
- **Fairness:** with both ports continuously requesting, grants alternate data, inst, data, … The first tie after reset goes to data.
- **Starvation bound:** either port waits at most one foreign transaction.

## Test plan
- **Single read:** `inst_req` = 1 with addr 0xBFC00000, `mem_addr_ok` in the first ADDR cycle, `mem_data_ok` 2 cycles later with rdata 0x3C1D0001. Required: `inst_addr_ok` and `inst_data_ok` each pulse once, `inst_rdata` = 0x3C1D0001, `data_addr_ok` and `data_data_ok` never assert.
- **Simultaneous requests after reset:** both ports request. Required: data is granted first, then inst, then data. `mem_addr` alternates between the data address and the inst address.
- **Withdrawn request:** `inst_req` is dropped one cycle after grant, while `mem_addr_ok` is held low for 3 cycles. Required: `mem_req` stays 1 with a stable `mem_addr` until accepted, and `inst_data_ok` still pulses.
- **Write:** data write with size 2, addr 0x80001000, wdata 0xDEADBEEF. Required: `mem_wr` = 1, `mem_size` = 2, and addr/wdata are held until `mem_data_ok`.
- **Spurious strobes and reset:** `mem_data_ok` pulses in IDLE, then `rst` is asserted during D_DATA. Required: no `data_ok` output, and all outputs return to 0 and IDLE the next cycle.

Source files
------------

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one sram-like port between inst and data masters, one transaction in flight, alternating on ties.
// A request seen in IDLE drives mem_req the next cycle; a requester is held off by withholding addr_ok until the shared port accepts.
module sram_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_I_ADDR,
    S_I_DATA,
    S_D_ADDR,
    S_D_DATA
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_last_owner;
  logic        r_mem_wr;
  logic [1:0]  r_mem_size;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic        w_arb;
  logic        w_grant;
  logic        w_pick_data;

  always_comb begin
    w_arb = (r_state == S_IDLE) ||
            (((r_state == S_I_DATA) || (r_state == S_D_DATA)) && mem_data_ok);
    w_grant = w_arb && (inst_req || data_req);
    // On a tie the port that did not own the previous transaction wins.
    w_pick_data = (inst_req && data_req) ? ~r_last_owner : data_req;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_I_ADDR:           if (mem_addr_ok) w_state_nxt = S_I_DATA;
      S_D_ADDR:           if (mem_addr_ok) w_state_nxt = S_D_DATA;
      S_I_DATA, S_D_DATA: if (mem_data_ok) w_state_nxt = S_IDLE;
      default:            w_state_nxt = r_state;
    endcase
    if (w_grant) w_state_nxt = w_pick_data ? S_D_ADDR : S_I_ADDR;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_last_owner <= 1'b0;
      r_mem_wr     <= 1'b0;
      r_mem_size   <= 2'd0;
      r_mem_addr   <= 32'd0;
      r_mem_wdata  <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_last_owner <= w_pick_data;
        r_mem_wr     <= w_pick_data ? data_wr    : inst_wr;
        r_mem_size   <= w_pick_data ? data_size  : inst_size;
        r_mem_addr   <= w_pick_data ? data_addr  : inst_addr;
        r_mem_wdata  <= w_pick_data ? data_wdata : inst_wdata;
      end
    end
  end

  // Strobes are gated by phase so stray mem_*_ok pulses never leak upstream.
  assign mem_req      = (r_state == S_I_ADDR) || (r_state == S_D_ADDR);
  assign mem_wr       = r_mem_wr;
  assign mem_size     = r_mem_size;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign inst_addr_ok = (r_state == S_I_ADDR) && mem_addr_ok;
  assign data_addr_ok = (r_state == S_D_ADDR) && mem_addr_ok;
  assign inst_data_ok = (r_state == S_I_DATA) && mem_data_ok;
  assign data_data_ok = (r_state == S_D_DATA) && mem_data_ok;
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: transaction-level model predicts grants, a monitor checks the DUT each cycle.
module tb_sram_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic [31:0] inst_rdata, data_rdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_addr_ok, mem_data_ok;

  sram_arbiter dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic        port;   // 0 = inst, 1 = data
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  txn_t        exp_q[$];
  logic [31:0] acc_log[$];
  int          i_aok_cnt = 0, d_aok_cnt = 0, i_dok_cnt = 0, d_dok_cnt = 0;

  // Reference model: a transaction is either absent, waiting for acceptance, or waiting for completion.
  int m_phase = 0;   // 0 none, 1 awaiting acceptance, 2 awaiting completion
  bit m_owner = 0, m_last = 0, clr_pending = 0;
  bit e_mem_req = 0, e_aok_i = 0, e_aok_d = 0, e_dok_i = 0, e_dok_d = 0;

  initial begin
    bit   do_arb, winner;
    txn_t t;
    forever begin
      @(negedge clk);
      if (clr_pending) begin
        exp_q.delete();
        clr_pending = 0;
      end
      e_mem_req = (m_phase == 1);
      e_aok_i   = (m_phase == 1) && !m_owner && mem_addr_ok;
      e_aok_d   = (m_phase == 1) &&  m_owner && mem_addr_ok;
      e_dok_i   = (m_phase == 2) && !m_owner && mem_data_ok;
      e_dok_d   = (m_phase == 2) &&  m_owner && mem_data_ok;
      if (rst) begin
        m_phase = 0;
        m_last = 0;
        clr_pending = 1;
      end else begin
        do_arb = (m_phase == 0) || (m_phase == 2 && mem_data_ok);
        if (m_phase == 1 && mem_addr_ok) m_phase = 2;
        if (do_arb) begin
          m_phase = 0;
          if (inst_req || data_req) begin
            winner  = (inst_req && data_req) ? !m_last : data_req;
            t.port  = winner;
            t.wr    = winner ? data_wr    : inst_wr;
            t.size  = winner ? data_size  : inst_size;
            t.addr  = winner ? data_addr  : inst_addr;
            t.wdata = winner ? data_wdata : inst_wdata;
            exp_q.push_back(t);
            m_last  = winner;
            m_owner = winner;
            m_phase = 1;
          end
        end
      end
    end
  end

  // Monitor: compares DUT outputs against the model each cycle, pops the scoreboard on completion.
  initial begin
    txn_t h;
    forever begin
      @(negedge clk);
      #1;
      check("mem_req", mem_req, e_mem_req);
      check("inst_addr_ok", inst_addr_ok, e_aok_i);
      check("data_addr_ok", data_addr_ok, e_aok_d);
      check("inst_data_ok", inst_data_ok, e_dok_i);
      check("data_data_ok", data_data_ok, e_dok_d);
      check("inst_rdata", inst_rdata, mem_rdata);
      check("data_rdata", data_rdata, mem_rdata);
      if (inst_addr_ok) i_aok_cnt++;
      if (data_addr_ok) d_aok_cnt++;
      if (inst_data_ok) i_dok_cnt++;
      if (data_data_ok) d_dok_cnt++;
      if (mem_req) begin
        check("txn_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          h = exp_q[0];
          check("mem_wr", mem_wr, h.wr);
          check("mem_size", mem_size, h.size);
          check("mem_addr", mem_addr, h.addr);
          check("mem_wdata", mem_wdata, h.wdata);
        end
        if (mem_addr_ok) acc_log.push_back(mem_addr);
      end
      if (inst_data_ok || data_data_ok) begin
        check("txn_for_data_ok", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          h = exp_q.pop_front();
          check("data_ok_owner", data_data_ok, h.port);
          check("held_mem_addr", mem_addr, h.addr);
          check("held_mem_wdata", mem_wdata, h.wdata);
        end
      end
    end
  end

  bit outst = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    inst_req = 0; data_req = 0; mem_addr_ok = 0; mem_data_ok = 0;
    tick();
    tick();
    rst = 0;
    outst = 0;
  endtask

  // mode 0: random requesters, 1: both held requesting, 2: no requests (drain)
  task automatic run_random(input int cycles, input int mode);
    bit hs_i, hs_d;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      hs_i = inst_req && inst_addr_ok;
      hs_d = data_req && data_addr_ok;
      if (mem_req && mem_addr_ok) outst = 1;
      else if (outst && mem_data_ok) outst = 0;
      tick();
      if (mode == 0) begin
        if (hs_i || !inst_req) begin
          inst_req = ($urandom_range(0, 3) != 0);
          inst_wr = 1'($urandom_range(0, 1)); inst_size = 2'($urandom_range(0, 3));
          inst_addr = $urandom; inst_wdata = $urandom;
        end else if ($urandom_range(0, 19) == 0) inst_req = 0;
        if (hs_d || !data_req) begin
          data_req = ($urandom_range(0, 3) != 0);
          data_wr = 1'($urandom_range(0, 1)); data_size = 2'($urandom_range(0, 3));
          data_addr = $urandom; data_wdata = $urandom;
        end else if ($urandom_range(0, 19) == 0) data_req = 0;
      end else begin
        inst_req = (mode == 1);
        data_req = (mode == 1);
      end
      mem_addr_ok = mem_req ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 7) == 0);
      mem_data_ok = outst   ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 7) == 0);
      mem_rdata   = $urandom;
    end
    mem_addr_ok = 0;
    mem_data_ok = 0;
  endtask

  initial begin
    int i0, d0, ia0, da0;
    rst = 1;
    inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
    mem_rdata = 0; mem_addr_ok = 0; mem_data_ok = 0;
    repeat (3) tick();
    rst = 0;
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_wr", mem_wr, 0);
    check("rst_mem_size", mem_size, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_oks", {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 0);

    // Single instruction read
    i0 = i_dok_cnt; d0 = d_dok_cnt; ia0 = i_aok_cnt; da0 = d_aok_cnt;
    inst_req = 1; inst_wr = 0; inst_size = 2; inst_addr = 32'hBFC00000;
    tick();
    mem_addr_ok = 1;
    #1;
    check("read_mem_addr", mem_addr, 32'hBFC00000);
    check("read_inst_addr_ok", inst_addr_ok, 1);
    tick();
    inst_req = 0; mem_addr_ok = 0;
    tick();
    mem_data_ok = 1; mem_rdata = 32'h3C1D0001;
    #1;
    check("read_inst_data_ok", inst_data_ok, 1);
    check("read_inst_rdata", inst_rdata, 32'h3C1D0001);
    tick();
    mem_data_ok = 0;
    tick();
    check("read_inst_aok_pulses", i_aok_cnt - ia0, 1);
    check("read_inst_dok_pulses", i_dok_cnt - i0, 1);
    check("read_data_oks", (d_aok_cnt - da0) + (d_dok_cnt - d0), 0);

    // Simultaneous requests after reset: data, inst, data
    do_reset();
    acc_log.delete();
    inst_wr = 0; inst_addr = 32'h00400000; data_wr = 0; data_addr = 32'h10010000;
    run_random(80, 1);
    run_random(30, 2);
    check("tie_grants", 32'(acc_log.size() >= 3), 1);
    if (acc_log.size() >= 3) begin
      check("tie_grant0_data", acc_log[0], 32'h10010000);
      check("tie_grant1_inst", acc_log[1], 32'h00400000);
      check("tie_grant2_data", acc_log[2], 32'h10010000);
    end

    // Withdrawn request: still completes on the shared port
    do_reset();
    i0 = i_dok_cnt;
    inst_req = 1; inst_wr = 0; inst_addr = 32'h00400100;
    tick();
    inst_req = 0; inst_addr = 32'h0BAD0000;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("withdraw_mem_req", mem_req, 1);
      check("withdraw_mem_addr", mem_addr, 32'h00400100);
      tick();
    end
    mem_addr_ok = 1;
    #1;
    check("withdraw_inst_addr_ok", inst_addr_ok, 1);
    tick();
    mem_addr_ok = 0; mem_data_ok = 1;
    #1;
    check("withdraw_inst_data_ok", inst_data_ok, 1);
    tick();
    mem_data_ok = 0;
    check("withdraw_dok_pulses", i_dok_cnt - i0, 1);

    // Data write with fields held until completion
    do_reset();
    data_req = 1; data_wr = 1; data_size = 2; data_addr = 32'h80001000; data_wdata = 32'hDEADBEEF;
    tick();
    mem_addr_ok = 1;
    #1;
    check("write_mem_wr", mem_wr, 1);
    check("write_mem_size", mem_size, 2);
    check("write_mem_addr", mem_addr, 32'h80001000);
    check("write_mem_wdata", mem_wdata, 32'hDEADBEEF);
    tick();
    data_req = 0; mem_addr_ok = 0; data_addr = 32'h12345678; data_wdata = 32'h0;
    tick();
    mem_data_ok = 1;
    #1;
    check("write_data_data_ok", data_data_ok, 1);
    check("write_held_addr", mem_addr, 32'h80001000);
    check("write_held_wdata", mem_wdata, 32'hDEADBEEF);
    tick();
    mem_data_ok = 0;

    // Spurious strobes in IDLE, then reset during D_DATA
    do_reset();
    d0 = d_dok_cnt;
    mem_data_ok = 1; mem_addr_ok = 1;
    #1;
    check("spur_oks", {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 0);
    tick();
    mem_data_ok = 0; mem_addr_ok = 0;
    #1;
    check("spur_stays_idle", mem_req, 0);
    data_req = 1; data_wr = 1; data_size = 1; data_addr = 32'h10010040; data_wdata = 32'hCAFEF00D;
    tick();
    mem_addr_ok = 1;
    tick();
    data_req = 0; mem_addr_ok = 0; rst = 1;
    tick();
    rst = 0;
    check("rstmid_mem_req", mem_req, 0);
    check("rstmid_mem_fields", {31'd0, mem_wr} | {30'd0, mem_size} | mem_addr | mem_wdata, 0);
    check("rstmid_oks", {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 0);
    mem_data_ok = 1;
    #1;
    check("rstmid_no_data_ok", data_data_ok, 0);
    tick();
    mem_data_ok = 0;
    check("rstmid_dok_pulses", d_dok_cnt - d0, 0);

    // Randomized traffic
    do_reset();
    run_random(3000, 0);
    run_random(40, 2);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
